dbus_bridge: RTL and testbench

- Sits directly downstream of the CPU core's data-memory port (daddr/dce/we/din/dm), between the core and the data block RAM.
- Decodes each access to either the data RAM or a small MMIO register window: LEDs, switches, and a compare-match timer.
- Returns read data with the fixed one-cycle latency the core's WB stage expects.
- Produces the timer interrupt line that feeds CP0 int_i bit 0.

---
 rtl/dbus_bridge_pkg.sv | 22 ++
 rtl/dbus_bridge_mmio_timer.sv | 46 ++++
 rtl/dbus_bridge.sv | 80 ++++++++
 tb/tb_dbus_bridge.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dbus_bridge_pkg.sv
// dbus_bridge_pkg: shared widths, MMIO offsets, TCTRL bit indices and byte-lane merge helper
package dbus_bridge_pkg;
  localparam int DATA_BUS = 32;
  localparam int DATA_ADDR_BUS = 32;
  localparam int DATA_WE_BUS = 4;
  localparam logic [15:0] LED_OFF = 16'h0000;
  localparam logic [15:0] SW_OFF = 16'h0004;
  localparam logic [15:0] COUNT_OFF = 16'h0008;
  localparam logic [15:0] COMPARE_OFF = 16'h000C;
  localparam logic [15:0] TCTRL_OFF = 16'h0010;
  localparam int TCTRL_EN = 0;
  localparam int TCTRL_PEND = 1;
  function automatic logic [DATA_BUS-1:0] byte_merge(
    input logic [DATA_BUS-1:0] old_v,
    input logic [DATA_BUS-1:0] new_v,
    input logic [DATA_WE_BUS-1:0] be
  );
    logic [DATA_BUS-1:0] r;
    for (int i = 0; i < DATA_WE_BUS; i++) r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dbus_bridge_mmio_timer.sv
// dbus_bridge_mmio_timer: free-running COUNT with COMPARE match, sticky PEND and registered interrupt
module dbus_bridge_mmio_timer
  import dbus_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_count,
  input  logic                   wr_compare,
  input  logic                   wr_tctrl,
  input  logic [DATA_WE_BUS-1:0] we,
  input  logic [DATA_BUS-1:0]    din,
  output logic [DATA_BUS-1:0]    count,
  output logic [DATA_BUS-1:0]    compare,
  output logic [DATA_BUS-1:0]    tctrl,
  output logic                   timer_int
);
  logic [DATA_BUS-1:0] count_q, compare_q;
  logic en_q, pend_q, int_q, match, clr;
  assign match = en_q & (count_q == compare_q);
  assign clr = wr_tctrl & we[0] & din[TCTRL_PEND];
  assign count = count_q;
  assign compare = compare_q;
  assign timer_int = int_q;
  // TCTRL read view: only EN and PEND are backed by state
  always_comb begin
    tctrl = '0;
    tctrl[TCTRL_EN] = en_q;
    tctrl[TCTRL_PEND] = pend_q;
  end
  // count/compare/control state; a match in the same cycle as a clear keeps PEND set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      compare_q <= '1;
      en_q <= 1'b0;
      pend_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      count_q <= wr_count ? byte_merge(count_q, din, we) : count_q + 32'd1;
      if (wr_compare) compare_q <= byte_merge(compare_q, din, we);
      if (wr_tctrl & we[0]) en_q <= din[TCTRL_EN];
      pend_q <= match | (pend_q & ~clr);
      int_q <= en_q & pend_q;
    end
  end
endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: data-port decode between RAM and MMIO (LED, SW, timer) with one-cycle read data
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
  parameter int LED_W = 16,
  parameter int SW_W = 16
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst_n,
  input  logic [DATA_ADDR_BUS-1:0] daddr,
  input  logic                     dce,
  input  logic [DATA_WE_BUS-1:0]   we,
  input  logic [DATA_BUS-1:0]      din,
  output logic [DATA_BUS-1:0]      dm,
  output logic                     ram_ce,
  output logic [DATA_WE_BUS-1:0]   ram_we,
  output logic [DATA_ADDR_BUS-1:0] ram_addr,
  output logic [DATA_BUS-1:0]      ram_din,
  input  logic [DATA_BUS-1:0]      ram_dout,
  input  logic [SW_W-1:0]          sw,
  output logic [LED_W-1:0]         led,
  output logic                     timer_int
);
  logic is_mmio, wr, rd_valid_q, rd_mmio_q;
  logic [15:0] off;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [DATA_BUS-1:0] led_ext, led_next, rdata, mmio_rdata_q, count, compare, tctrl;
  assign is_mmio = dce & (daddr[31:16] == MMIO_BASE[31:16]);
  assign ram_ce = dce & ~is_mmio;
  assign ram_we = ram_ce ? we : '0;
  assign ram_addr = daddr;
  assign ram_din = din;
  assign off = {daddr[15:2], 2'b00};
  assign wr = is_mmio & |we;
  assign led = led_q;
  assign led_ext = DATA_BUS'(led_q);
  assign led_next = byte_merge(led_ext, din, we);
  assign dm = rd_valid_q ? (rd_mmio_q ? mmio_rdata_q : ram_dout) : '0;
  dbus_bridge_mmio_timer u_timer (
    .clk(cpu_clk_50M),
    .rst_n(cpu_rst_n),
    .wr_count(wr && off == COUNT_OFF),
    .wr_compare(wr && off == COMPARE_OFF),
    .wr_tctrl(wr && off == TCTRL_OFF),
    .we(we),
    .din(din),
    .count(count),
    .compare(compare),
    .tctrl(tctrl),
    .timer_int(timer_int)
  );
  // MMIO read mux over the current (pre-update) register values
  always_comb begin
    rdata = off == LED_OFF ? led_ext :
            off == SW_OFF ? DATA_BUS'(sw_s2) :
            off == COUNT_OFF ? count :
            off == COMPARE_OFF ? compare :
            off == TCTRL_OFF ? tctrl : '0;
  end
  // LED register, switch synchroniser and the registered read path
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led_q <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      rd_valid_q <= 1'b0;
      rd_mmio_q <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      if (wr && off == LED_OFF) led_q <= led_next[LED_W-1:0];
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      rd_valid_q <= dce & ~|we;
      rd_mmio_q <= is_mmio;
      mmio_rdata_q <= is_mmio ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: directed self-checking bench for dbus_bridge
module tb_dbus_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] daddr = '0;
  logic        dce = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] din = '0;
  logic [31:0] dm;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        timer_int;
  logic [31:0] mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] A_LED = 32'hBFAF_0000;
  localparam logic [31:0] A_SW = 32'hBFAF_0004;
  localparam logic [31:0] A_CNT = 32'hBFAF_0008;
  localparam logic [31:0] A_CMP = 32'hBFAF_000C;
  localparam logic [31:0] A_TC = 32'hBFAF_0010;

  dbus_bridge dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .daddr(daddr), .dce(dce), .we(we), .din(din),
    .dm(dm), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .sw(sw), .led(led), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr[5:2]][b*8 +: 8] <= ram_din[b*8 +: 8];
      ram_dout <= mem[ram_addr[5:2]];
    end
  end

  task automatic acc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    daddr = a; dce = 1'b1; we = w; din = d;
    @(posedge clk); #1;
    dce = 1'b0; we = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL reset_dm: got %h want %h", dm, 32'h0); end
    n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
    n_cmp++; if (timer_int !== 1'b0) begin n_bad++; $display("FAIL reset_int: got %b want 0", timer_int); end
    acc(A_TC, 4'h0, 0);
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL reset_tctrl: got %h want %h", dm, 32'h0); end
    acc(A_CMP, 4'h0, 0);
    n_cmp++; if (dm !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_compare: got %h want %h", dm, 32'hFFFF_FFFF); end
  endtask

  task automatic test_ram();
    daddr = 32'h0000_0010; dce = 1'b1; we = 4'hF; din = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (ram_ce !== 1'b1) begin n_bad++; $display("FAIL ram_ce: got %b want 1", ram_ce); end
    n_cmp++; if (ram_we !== 4'hF) begin n_bad++; $display("FAIL ram_we: got %h want f", ram_we); end
    n_cmp++; if (ram_addr !== 32'h10 || ram_din !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_pass: got %h/%h want 00000010/deadbeef", ram_addr, ram_din); end
    @(posedge clk); #1;
    dce = 1'b0; we = '0;
    n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL ram_no_mmio: got %h want 0000", led); end
    acc(32'h0000_0010, 4'h0, 0);
    n_cmp++; if (dm !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_read: got %h want %h", dm, 32'hDEAD_BEEF); end
    idle();
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL dm_idle: got %h want 0", dm); end
  endtask

  task automatic test_led();
    daddr = A_LED; dce = 1'b1; we = 4'hF; din = 32'h0000_A5A5;
    #1;
    n_cmp++; if (ram_ce !== 1'b0 || ram_we !== 4'h0) begin n_bad++; $display("FAIL mmio_ram_ce: got %b/%h want 0/0", ram_ce, ram_we); end
    @(posedge clk); #1;
    dce = 1'b0; we = '0;
    n_cmp++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL led_full: got %h want a5a5", led); end
    acc(A_LED, 4'b0010, 32'h0000_3C00);
    n_cmp++; if (led !== 16'h3CA5) begin n_bad++; $display("FAIL led_lane: got %h want 3ca5", led); end
    acc(A_LED, 4'h0, 0);
    n_cmp++; if (dm !== 32'h0000_3CA5) begin n_bad++; $display("FAIL led_read: got %h want 00003ca5", dm); end
  endtask

  task automatic test_sw();
    sw = 16'h00F0;
    repeat (3) idle();
    acc(A_SW, 4'h0, 0);
    n_cmp++; if (dm !== 32'h0000_00F0) begin n_bad++; $display("FAIL sw_read: got %h want 000000f0", dm); end
    acc(A_SW, 4'hF, 32'hFFFF_FFFF);
    acc(A_SW, 4'h0, 0);
    n_cmp++; if (dm !== 32'h0000_00F0) begin n_bad++; $display("FAIL sw_ro: got %h want 000000f0", dm); end
    n_cmp++; if (led !== 16'h3CA5) begin n_bad++; $display("FAIL sw_wr_led: got %h want 3ca5", led); end
  endtask

  task automatic test_back_to_back();
    acc(A_CMP, 4'hF, 32'h1234_5678);
    acc(A_CMP, 4'h0, 0);
    n_cmp++; if (dm !== 32'h1234_5678) begin n_bad++; $display("FAIL b2b_compare: got %h want 12345678", dm); end
    acc(A_CMP, 4'b0001, 32'h0000_00AA);
    acc(A_CMP, 4'h0, 0);
    n_cmp++; if (dm !== 32'h1234_56AA) begin n_bad++; $display("FAIL compare_lane: got %h want 123456aa", dm); end
    acc(A_CNT, 4'hF, 32'd100);
    acc(A_CNT, 4'h0, 0);
    n_cmp++; if (dm !== 32'd100) begin n_bad++; $display("FAIL count_read: got %0d want 100", dm); end
    acc(A_CNT, 4'h0, 0);
    n_cmp++; if (dm !== 32'd101) begin n_bad++; $display("FAIL count_inc: got %0d want 101", dm); end
    acc(A_CNT, 4'hF, 32'hFFFF_FFFF);
    idle();
    acc(A_CNT, 4'h0, 0);
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL count_wrap: got %h want 0", dm); end
  endtask

  task automatic test_timer();
    acc(A_CNT, 4'hF, 32'd0);
    acc(A_CMP, 4'hF, 32'd10);
    acc(A_TC, 4'hF, 32'd1);
    repeat (9) idle();
    n_cmp++; if (timer_int !== 1'b0) begin n_bad++; $display("FAIL timer_early: got %b want 0", timer_int); end
    acc(A_TC, 4'h0, 0);
    n_cmp++; if (timer_int !== 1'b1) begin n_bad++; $display("FAIL timer_fire: got %b want 1", timer_int); end
    n_cmp++; if (dm !== 32'h3) begin n_bad++; $display("FAIL timer_pend: got %h want 3", dm); end
    acc(A_TC, 4'hF, 32'h3);
    idle();
    n_cmp++; if (timer_int !== 1'b0) begin n_bad++; $display("FAIL timer_clear: got %b want 0", timer_int); end
    acc(A_TC, 4'h0, 0);
    n_cmp++; if (dm !== 32'h1) begin n_bad++; $display("FAIL tctrl_after_clr: got %h want 1", dm); end
  endtask

  task automatic test_collision();
    acc(A_CMP, 4'hF, 32'd5);
    acc(A_CNT, 4'hF, 32'd3);
    idle();
    idle();
    acc(A_TC, 4'hF, 32'h3);
    acc(A_TC, 4'h0, 0);
    n_cmp++; if (dm !== 32'h3) begin n_bad++; $display("FAIL collide_pend: got %h want 3", dm); end
    n_cmp++; if (timer_int !== 1'b1) begin n_bad++; $display("FAIL collide_int: got %b want 1", timer_int); end
  endtask

  task automatic test_reset_mid();
    daddr = 32'h0000_0010; dce = 1'b1; we = 4'h0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    dce = 1'b0;
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL rst_dm_hold: got %h want 0", dm); end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++; if (led !== 16'h0 || timer_int !== 1'b0) begin n_bad++; $display("FAIL rst_outs: got %h/%b want 0000/0", led, timer_int); end
    idle();
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL rst_discard: got %h want 0", dm); end
    acc(A_CMP, 4'h0, 0);
    n_cmp++; if (dm !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_compare: got %h want ffffffff", dm); end
  endtask

  task automatic test_unmapped();
    acc(32'hBFAF_0020, 4'hF, 32'hFFFF_FFFF);
    acc(32'hBFAF_0020, 4'h0, 0);
    n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL unmapped: got %h want 0", dm); end
    n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL unmapped_led: got %h want 0000", led); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_sw();
    test_back_to_back();
    test_timer();
    test_collision();
    test_reset_mid();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
